// File: rtl/ram_axi_bridge_pkg.sv
// Shared types and constants for the RAM-to-AXI bridge: widths, AXI size codes,
// FSM state encoding and the latched request payload.
package ram_axi_bridge_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned SIZE_W = 3;
    localparam int unsigned OFF_W  = 3;
    localparam int unsigned BSH_W  = OFF_W + 3;
    localparam int unsigned MASK_W = 16;
    localparam int unsigned CNT_W  = 4;

    localparam logic [SIZE_W-1:0] AXI_SIZE_1B = 3'd0;
    localparam logic [SIZE_W-1:0] AXI_SIZE_2B = 3'd1;
    localparam logic [SIZE_W-1:0] AXI_SIZE_4B = 3'd2;
    localparam logic [SIZE_W-1:0] AXI_SIZE_8B = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4,
        ST_RESP = 3'd5
    } state_e;

    // Request as held for the duration of one transaction; write data/strobe lane-aligned.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    // Byte count of an AXI size code; codes above 8 bytes saturate to a full beat.
    function automatic logic [CNT_W-1:0] size_bytes(input logic [SIZE_W-1:0] size);
        logic [CNT_W-1:0] n;
        case (size)
            AXI_SIZE_1B: n = CNT_W'(1);
            AXI_SIZE_2B: n = CNT_W'(2);
            AXI_SIZE_4B: n = CNT_W'(4);
            AXI_SIZE_8B: n = CNT_W'(8);
            default:     n = CNT_W'(8);
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ram_axi_bridge_if.sv
// Bus bundle for the bridge: simple RAM request port plus the five AXI channels.
interface ram_axi_bridge_if;
    import ram_axi_bridge_pkg::*;

    logic [ADDR_W-1:0] i_ram_addr;
    logic              i_ram_wen;
    logic              i_ram_valid;
    logic [DATA_W-1:0] i_ram_wdata;
    logic [SIZE_W-1:0] i_ram_size;
    logic              o_ram_ready;
    logic [DATA_W-1:0] o_ram_rdata;

    logic [ADDR_W-1:0] o_axi_awaddr;
    logic              o_axi_awvalid;
    logic              i_axi_awready;
    logic [SIZE_W-1:0] o_axi_awsize;

    logic [DATA_W-1:0] o_axi_wdata;
    logic [STRB_W-1:0] o_axi_wstrb;
    logic              o_axi_wvalid;
    logic              i_axi_wready;

    logic              i_axi_bvalid;
    logic              o_axi_bready;

    logic [ADDR_W-1:0] o_axi_araddr;
    logic              o_axi_arvalid;
    logic              i_axi_arready;
    logic [SIZE_W-1:0] o_axi_arsize;

    logic [DATA_W-1:0] i_axi_rdata;
    logic              i_axi_rvalid;
    logic              o_axi_rready;

    // Bridge side.
    modport master (
        input  i_ram_addr, i_ram_wen, i_ram_valid, i_ram_wdata, i_ram_size,
        output o_ram_ready, o_ram_rdata,
        output o_axi_awaddr, o_axi_awvalid, o_axi_awsize,
        input  i_axi_awready,
        output o_axi_wdata, o_axi_wstrb, o_axi_wvalid,
        input  i_axi_wready,
        input  i_axi_bvalid,
        output o_axi_bready,
        output o_axi_araddr, o_axi_arvalid, o_axi_arsize,
        input  i_axi_arready,
        input  i_axi_rdata, i_axi_rvalid,
        output o_axi_rready
    );

    // Requester plus AXI slave side.
    modport slave (
        output i_ram_addr, i_ram_wen, i_ram_valid, i_ram_wdata, i_ram_size,
        input  o_ram_ready, o_ram_rdata,
        input  o_axi_awaddr, o_axi_awvalid, o_axi_awsize,
        output i_axi_awready,
        input  o_axi_wdata, o_axi_wstrb, o_axi_wvalid,
        output i_axi_wready,
        output i_axi_bvalid,
        input  o_axi_bready,
        input  o_axi_araddr, o_axi_arvalid, o_axi_arsize,
        output i_axi_arready,
        output i_axi_rdata, i_axi_rvalid,
        input  o_axi_rready
    );

endinterface

// File: rtl/ram_axi_bridge_align.sv
// Byte-lane steering between right-aligned RAM data and the 64-bit AXI beat.
module ram_axi_align
    import ram_axi_bridge_pkg::*;
(
    input  logic [OFF_W-1:0]  off_i,
    input  logic [SIZE_W-1:0] size_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] wdata_c_o,
    output logic [STRB_W-1:0] wstrb_c_o,
    output logic [DATA_W-1:0] rdata_c_o
);

    logic [BSH_W-1:0]  bit_sh;
    logic [MASK_W-1:0] mask;

    // Strobe is computed wide so an 8-byte mask survives before truncation to the beat.
    always_comb begin
        bit_sh    = {off_i, 3'b000};
        mask      = (MASK_W'(1) << size_bytes(size_i)) - MASK_W'(1);
        wdata_c_o = wdata_i << bit_sh;
        rdata_c_o = rdata_i >> bit_sh;
        wstrb_c_o = STRB_W'(mask << off_i);
    end

endmodule

// File: rtl/ram_axi_bridge.sv
// Single-outstanding bridge from a valid/ready RAM request port to an AXI master;
// every bus-facing output comes straight from a flop.
module ram_axi_bridge
    import ram_axi_bridge_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    ram_axi_bridge_if.master bus
);

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [OFF_W-1:0]  lane_off;
    logic [DATA_W-1:0] lane_wdata;
    logic [STRB_W-1:0] lane_wstrb;
    logic [DATA_W-1:0] lane_rdata;

    // Lanes follow the incoming request while idle and the frozen request otherwise.
    assign lane_off = (state_q == ST_IDLE) ? bus.i_ram_addr[OFF_W-1:0]
                                           : req_q.addr[OFF_W-1:0];

    ram_axi_align u_align (
        .off_i     (lane_off),
        .size_i    (bus.i_ram_size),
        .wdata_i   (bus.i_ram_wdata),
        .rdata_i   (bus.i_axi_rdata),
        .wdata_c_o (lane_wdata),
        .wstrb_c_o (lane_wstrb),
        .rdata_c_o (lane_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
        end
    end

    // Next-state logic also produces the next value of every registered output.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        ready_d   = 1'b0;
        rdata_d   = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_ram_valid) begin
                    req_d.addr  = bus.i_ram_addr;
                    req_d.size  = bus.i_ram_size;
                    req_d.wdata = lane_wdata;
                    req_d.wstrb = bus.i_ram_wen ? lane_wstrb : '0;
                    if (bus.i_ram_wen) begin
                        state_d   = ST_AW_W;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end

            ST_AR: begin
                arvalid_d = 1'b1;
                if (bus.i_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_R;
                end
            end

            ST_R: begin
                rready_d = 1'b1;
                if (bus.i_axi_rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = lane_rdata;
                    ready_d  = 1'b1;
                    state_d  = ST_RESP;
                end
            end

            // Address and data handshakes retire independently, in either order.
            ST_AW_W: begin
                awvalid_d = awvalid_q && !bus.i_axi_awready;
                wvalid_d  = wvalid_q && !bus.i_axi_wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = ST_B;
                end
            end

            ST_B: begin
                bready_d = 1'b1;
                if (bus.i_axi_bvalid) begin
                    bready_d = 1'b0;
                    ready_d  = 1'b1;
                    state_d  = ST_RESP;
                end
            end

            ST_RESP: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.o_ram_ready   = ready_q;
    assign bus.o_ram_rdata   = rdata_q;
    assign bus.o_axi_araddr  = req_q.addr;
    assign bus.o_axi_arsize  = req_q.size;
    assign bus.o_axi_arvalid = arvalid_q;
    assign bus.o_axi_rready  = rready_q;
    assign bus.o_axi_awaddr  = req_q.addr;
    assign bus.o_axi_awsize  = req_q.size;
    assign bus.o_axi_awvalid = awvalid_q;
    assign bus.o_axi_wdata   = req_q.wdata;
    assign bus.o_axi_wstrb   = req_q.wstrb;
    assign bus.o_axi_wvalid  = wvalid_q;
    assign bus.o_axi_bready  = bready_q;

endmodule
